// File: rtl/reg_writeback_queue.sv
// -----------------------------------------------------------------------------
// reg_writeback_queue
//
// Purpose:
//   Holds register-write requests from the execute/memory stages in a small
//   circular FIFO. The FIFO drains into the 32x32 register file write port at
//   most one entry per cycle. It also offers a combinational read bypass, so
//   operand fetch can see pending writes that have not reached the register
//   file yet.
//
// Parameters:
//   DEPTH        number of pending-write entries (power of 2, >= 2)
//
// Ports:
//   clock        single clock; all state updates on the rising edge
//   reset        asynchronous, active-high; clears every pending entry
//   in_valid     write request present
//   in_rd        destination register of the request
//   in_data      write data of the request
//   in_ready     queue can take a request this cycle (count < DEPTH)
//   K_Regwrite   register file write strobe (queue not empty)
//   rd           register file write address (head entry, 0 when empty)
//   K_write_data register file write data (head entry, 0 when empty)
//   rf_ready     register file accepts the presented write this cycle
//   rs, rt       operand-fetch read addresses
//   byp_rs_hit   a pending write exists for rs
//   byp_rt_hit   a pending write exists for rt
//   byp_rs_data  data of the youngest pending write to rs (0 on miss)
//   byp_rt_data  data of the youngest pending write to rt (0 on miss)
//   count        number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [4:0]               in_rd,
  input  logic [31:0]              in_data,
  output logic                     in_ready,
  output logic                     K_Regwrite,
  output logic [4:0]               rd,
  output logic [31:0]              K_write_data,
  input  logic                     rf_ready,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  output logic                     byp_rs_hit,
  output logic                     byp_rt_hit,
  output logic [31:0]              byp_rs_data,
  output logic [31:0]              byp_rt_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry storage. The storage is not reset: an entry only matters while it
  // lies inside the [head, head+count) window, and the reset empties that
  // window.
  logic [4:0]    rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;

  // ---------------------------------------------------------------------------
  // Handshake and drain
  // ---------------------------------------------------------------------------
  // in_ready depends only on the registered count. A drain in the same cycle
  // does not free a slot for the incoming request until the next edge.
  assign in_ready   = (count_q < DEPTH_C);
  assign K_Regwrite = (count_q != '0);

  // A request to r0 completes its handshake but is never stored.
  assign push = in_valid && in_ready && (in_rd != 5'd0);
  assign pop  = K_Regwrite && rf_ready;

  assign rd           = K_Regwrite ? rd_mem_q[head_q]   : 5'd0;
  assign K_write_data = K_Regwrite ? data_mem_q[head_q] : 32'd0;
  assign count        = count_q;

  // ---------------------------------------------------------------------------
  // Pointer / occupancy next state
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry write. push already covers the full and r0 cases, so a slot that
  // is still waiting to drain is never overwritten.
  always_ff @(posedge clock) begin
    if (push) begin
      rd_mem_q[tail_q]   <= in_rd;
      data_mem_q[tail_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Bypass search
  // ---------------------------------------------------------------------------
  // age[gi] is the distance of slot gi from the head: 0 is the oldest entry.
  // A slot is valid when its age is below count. The head stays in the search
  // in the cycle it drains, because the search uses the registered state. A
  // request arriving in the same cycle is not in the search yet.
  logic [PW-1:0] age       [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] rs_match;
  logic [DEPTH-1:0] rt_match;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign age[gi]         = PW'(gi) - head_q;
    assign entry_valid[gi] = ({1'b0, age[gi]} < count_q);
    assign rs_match[gi]    = entry_valid[gi] && (rs != 5'd0) &&
                             (rd_mem_q[gi] == rs);
    assign rt_match[gi]    = entry_valid[gi] && (rt != 5'd0) &&
                             (rd_mem_q[gi] == rt);
  end

  assign byp_rs_hit = |rs_match;
  assign byp_rt_hit = |rt_match;

  // Pick the matching entry with the largest age, which is the youngest write.
  logic [PW-1:0] rs_best_age;
  logic [PW-1:0] rt_best_age;

  always_comb begin
    byp_rs_data = 32'd0;
    byp_rt_data = 32'd0;
    rs_best_age = '0;
    rt_best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rs_match[i] && (age[i] >= rs_best_age)) begin
        rs_best_age = age[i];
        byp_rs_data = data_mem_q[i];
      end
      if (rt_match[i] && (age[i] >= rt_best_age)) begin
        rt_best_age = age[i];
        byp_rt_data = data_mem_q[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        K_Regwrite;
  logic [4:0]  rd;
  logic [31:0] K_write_data;
  logic        rf_ready = 1'b0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic        byp_rs_hit, byp_rt_hit;
  logic [31:0] byp_rs_data, byp_rt_data;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_fail   = 0;

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_rd(in_rd), .in_data(in_data), .in_ready(in_ready),
    .K_Regwrite(K_Regwrite), .rd(rd), .K_write_data(K_write_data),
    .rf_ready(rf_ready), .rs(rs), .rt(rt),
    .byp_rs_hit(byp_rs_hit), .byp_rt_hit(byp_rt_hit),
    .byp_rs_data(byp_rs_data), .byp_rt_data(byp_rt_data),
    .count(count)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model: a plain queue of pending writes ------
  typedef struct packed { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t mq[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = (mq.size() != 0) && rf_ready;
      do_push = in_valid && (mq.size() < DEPTH) && (in_rd != 5'd0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back('{r: in_rd, d: in_data});
    end
  end

  function automatic void model_byp(input logic [4:0] a, output logic h,
                                    output logic [31:0] d);
    h = 1'b0;
    d = 32'd0;
    if (a != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].r == a) begin
          h = 1'b1;
          d = mq[i].d;
          break;
        end
      end
    end
  endfunction

  // ---------------- per-cycle comparison against the model ------------------
  always @(negedge clock) begin
    logic        e_rdy, e_k, e_hs, e_ht;
    logic [4:0]  e_rd;
    logic [31:0] e_wd, e_ds, e_dt;
    int          e_cnt;
    e_cnt = mq.size();
    e_rdy = (e_cnt < DEPTH);
    e_k   = (e_cnt != 0);
    e_rd  = e_k ? mq[0].r : 5'd0;
    e_wd  = e_k ? mq[0].d : 32'd0;
    model_byp(rs, e_hs, e_ds);
    model_byp(rt, e_ht, e_dt);
    n_checks++;
    if (int'(count) != e_cnt || in_ready !== e_rdy || K_Regwrite !== e_k ||
        rd !== e_rd || K_write_data !== e_wd || byp_rs_hit !== e_hs ||
        byp_rs_data !== e_ds || byp_rt_hit !== e_ht || byp_rt_data !== e_dt) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t got cnt=%0d rdy=%b k=%b rd=%0d wd=%h rs=%b/%h rt=%b/%h exp cnt=%0d rdy=%b k=%b rd=%0d wd=%h rs=%b/%h rt=%b/%h",
               $time, count, in_ready, K_Regwrite, rd, K_write_data,
               byp_rs_hit, byp_rs_data, byp_rt_hit, byp_rt_data,
               e_cnt, e_rdy, e_k, e_rd, e_wd, e_hs, e_ds, e_ht, e_dt);
    end else begin
      $display("cycle t=%0t cnt=%0d k=%b rd=%0d wd=%h", $time, count, K_Regwrite, rd, K_write_data);
    end
  end

  // ---------------- directed stimulus with literal expectations -------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end else begin
      $display("check %s = %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [4:0] r, input logic [31:0] d);
    in_valid = 1'b1;
    in_rd    = r;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_kreg", 32'(K_Regwrite), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    reset = 1'b0;

    // Single write, then drain
    rf_ready = 1'b0;
    send(5'd5, 32'h12C);
    chk("single_kreg", 32'(K_Regwrite), 32'd1);
    chk("single_rd", 32'(rd), 32'd5);
    chk("single_wd", K_write_data, 32'h12C);
    chk("single_cnt", 32'(count), 32'd1);
    rf_ready = 1'b1;
    step();
    chk("single_drain_cnt", 32'(count), 32'd0);
    chk("single_drain_kreg", 32'(K_Regwrite), 32'd0);
    rf_ready = 1'b0;

    // Fill to full, hold the 5th request, drain one, then accept it
    for (int i = 1; i <= 4; i++) send(5'(i), 32'h100 + 32'(i));
    chk("full_cnt", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_head_rd", 32'(rd), 32'd1);
    in_valid = 1'b1; in_rd = 5'd5; in_data = 32'h105;
    step();
    chk("full_held_cnt", 32'(count), 32'd4);
    rf_ready = 1'b1;
    step();
    chk("full_drain_cnt", 32'(count), 32'd3);
    chk("full_drain_ready", 32'(in_ready), 32'd1);
    rf_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("full_5th_cnt", 32'(count), 32'd4);
    rf_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("order_rd_%0d", k), 32'(rd), 32'(k));
      step();
    end
    chk("order_empty", 32'(count), 32'd0);
    rf_ready = 1'b0;

    // Duplicate rd: bypass returns the youngest, drain writes the oldest first
    send(5'd7, 32'hA);
    send(5'd7, 32'hB);
    rs = 5'd7; rt = 5'd7;
    #1;
    chk("dup_rs_hit", 32'(byp_rs_hit), 32'd1);
    chk("dup_rs_data", byp_rs_data, 32'hB);
    chk("dup_rt_data", byp_rt_data, 32'hB);
    chk("dup_first_wd", K_write_data, 32'hA);
    rt = 5'd3;
    #1;
    chk("dup_rt_miss", 32'(byp_rt_hit), 32'd0);
    rf_ready = 1'b1;
    step();
    chk("dup_second_wd", K_write_data, 32'hB);
    chk("dup_still_hit", byp_rs_data, 32'hB);
    step();
    chk("dup_after_hit", 32'(byp_rs_hit), 32'd0);
    chk("dup_after_cnt", 32'(count), 32'd0);
    rf_ready = 1'b0; rs = 5'd0; rt = 5'd0;

    // r0 request: handshake completes, nothing stored, r0 never bypasses
    in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFFFF;
    #1;
    chk("r0_ready", 32'(in_ready), 32'd1);
    step();
    chk("r0_cnt", 32'(count), 32'd0);
    chk("r0_kreg", 32'(K_Regwrite), 32'd0);
    chk("r0_byp", 32'(byp_rs_hit), 32'd0);
    // Same-cycle incoming request is not bypassed
    in_rd = 5'd20; in_data = 32'h55; rs = 5'd20;
    #1;
    chk("incoming_no_byp", 32'(byp_rs_hit), 32'd0);
    step();
    in_valid = 1'b0;
    chk("incoming_then_hit", byp_rs_data, 32'h55);
    rf_ready = 1'b1;
    step();
    chk("incoming_drained", 32'(count), 32'd0);
    rf_ready = 1'b0; rs = 5'd0;

    // Steady streaming at count 3 for 2*DEPTH cycles: pointers wrap
    for (int r = 10; r <= 12; r++) send(5'(r), 32'h1000 + 32'(r));
    chk("stream_start_cnt", 32'(count), 32'd3);
    rf_ready = 1'b1;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      in_valid = 1'b1; in_rd = 5'(13 + k); in_data = 32'h1000 + 32'(13 + k);
      #1;
      chk($sformatf("stream_rd_%0d", k), 32'(rd), 32'(10 + k));
      step();
      chk($sformatf("stream_cnt_%0d", k), 32'(count), 32'd3);
    end
    in_valid = 1'b0;
    for (int r = 18; r <= 20; r++) begin
      chk($sformatf("stream_tail_rd_%0d", r), K_write_data, 32'h1000 + 32'(r));
      step();
    end
    chk("stream_end_cnt", 32'(count), 32'd0);
    rf_ready = 1'b0;

    // Reset asserted between edges with two pending entries
    send(5'd14, 32'h14);
    send(5'd15, 32'h15);
    chk("mid_rst_pre_cnt", 32'(count), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_kreg", 32'(K_Regwrite), 32'd0);
    chk("mid_rst_cnt", 32'(count), 32'd0);
    chk("mid_rst_rd", 32'(rd), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    step();
    step();
    reset = 1'b0;
    send(5'd9, 32'h1);
    chk("post_rst_rd", 32'(rd), 32'd9);
    chk("post_rst_wd", K_write_data, 32'h1);
    chk("post_rst_cnt", 32'(count), 32'd1);
    rf_ready = 1'b1;
    step();
    chk("post_rst_drain", 32'(count), 32'd0);
    rf_ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
